// File: rtl/fir_seq_ctrl.sv
// Frame sequencer for a streaming FIR: primes with zeros, streams a frame,
// flushes with zeros, drains, then pulses done. Filter outputs are re-timed
// through a valid delay line and captured into m_data.
// Ports: clk, sclr (async, active-high), start, abort, s_valid/s_ready/s_data
//   (sample source), fir_rfd/fir_nd/fir_din (filter input side),
//   fir_data_valid/fir_dout (filter output side), m_valid/m_data (captured
//   result), busy, done, out_cnt (results emitted this frame).
module fir_seq_ctrl #(
  parameter int PRIME_LEN = 107,
  parameter int FRAME_LEN = 128,
  parameter int FLUSH_LEN = 43,
  parameter int DRAIN_LEN = 20,
  parameter int OUT_DLY   = 2
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        fir_rfd,
  output logic        fir_nd,
  output logic [15:0] fir_din,
  input  logic        fir_data_valid,
  input  logic [31:0] fir_dout,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] out_cnt
);

  localparam int MAX_A = (PRIME_LEN > FRAME_LEN) ? PRIME_LEN : FRAME_LEN;
  localparam int MAX_B = (FLUSH_LEN > DRAIN_LEN) ? FLUSH_LEN : DRAIN_LEN;
  localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXL < 2) ? 1 : $clog2(MAXL);

  localparam logic [CW-1:0] P_LAST =
    CW'((PRIME_LEN > 0) ? PRIME_LEN - 1 : 0);
  localparam logic [CW-1:0] S_LAST =
    CW'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);
  localparam logic [CW-1:0] F_LAST =
    CW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [CW-1:0] D_LAST =
    CW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   m_data_q, m_data_d;
  logic [15:0]   out_cnt_q, out_cnt_d;
  logic          clr_dly;
  logic          kill;
  logic          go;
  logic          tap;
  logic          fvin;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign out_cnt = out_cnt_q;
  assign kill    = abort & busy;
  assign fvin    = fir_data_valid & busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fir_nd  = 1'b0;
    fir_din = '0;
    s_ready = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A start coinciding with done is swallowed by the finishing frame.
        if (start && !abort && !done_q) begin
          state_d = S_PRIME;
          cnt_d   = '0;
          go      = 1'b1;
        end
      end
      S_PRIME: begin
        if (PRIME_LEN == 0) begin
          state_d = S_STREAM;
        end else begin
          fir_nd = fir_rfd;
          if (fir_nd) begin
            if (cnt_q == P_LAST) begin
              state_d = S_STREAM;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_STREAM: begin
        if (FRAME_LEN == 0) begin
          state_d = S_FLUSH;
        end else begin
          s_ready = fir_rfd;
          fir_din = s_data;
          fir_nd  = s_valid & fir_rfd;
          if (fir_nd) begin
            if (cnt_q == S_LAST) begin
              state_d = S_FLUSH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (FLUSH_LEN == 0) begin
          state_d = S_DRAIN;
        end else begin
          fir_nd = fir_rfd;
          if (fir_nd) begin
            if (cnt_q == F_LAST) begin
              state_d = S_DRAIN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (DRAIN_LEN == 0 || cnt_q == D_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      fir_nd  = 1'b0;
      s_ready = 1'b0;
    end
  end

  assign clr_dly = go | kill;

  generate
    if (OUT_DLY == 0) begin : g_nodly
      assign tap = fvin;
    end else begin : g_dly
      logic [OUT_DLY-1:0] dv_q, dv_d;
      always_comb begin
        dv_d = (dv_q << 1) | OUT_DLY'(fvin);
        if (clr_dly) dv_d = '0;
      end
      always_ff @(posedge clk or posedge sclr) begin
        if (sclr) dv_q <= '0;
        else      dv_q <= dv_d;
      end
      assign tap = dv_q[OUT_DLY-1];
    end
  endgenerate

  always_comb begin
    m_valid_d = tap & busy & ~kill;
    m_data_d  = m_valid_d ? fir_dout : m_data_q;
    out_cnt_d = out_cnt_q;
    if (go) begin
      out_cnt_d = '0;
    end else if (m_valid_q && out_cnt_q != 16'hFFFF) begin
      out_cnt_d = out_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a 4-tap behavioural filter model.
// Each scenario task drives a frame and checks its own results inline.
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        sclr, start, abort, s_valid, s_ready, fir_rfd, fir_nd;
  logic        fir_data_valid, m_valid, busy, done;
  logic [15:0] s_data, fir_din, out_cnt;
  logic [31:0] fir_dout, m_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk(clk), .sclr(sclr), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_rfd(fir_rfd), .fir_nd(fir_nd), .fir_din(fir_din),
    .fir_data_valid(fir_data_valid), .fir_dout(fir_dout),
    .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .done(done), .out_cnt(out_cnt)
  );

  int nd_total, xfer, zero_bad, bad_rfd, bad_ready, bad_gap;
  int first_nd, done_at, done_cnt, mv_cnt, abort_k, sclr_k;
  int nd_on_abort, busy_after_abort, timeout;
  logic [6:0]  sclr_snap;
  logic [15:0] slog [0:127];
  logic [31:0] mlog [0:511];
  logic [31:0] taps [4];
  logic [15:0] hist [4];
  logic [31:0] yp   [3];
  logic        nd_prev;

  task automatic run_frame(input int rfd_mode, input int sv_mode,
                           input int dmode, input int abort_at,
                           input int sclr_at_nd, input int restart_at);
    logic [31:0] y;
    nd_total = 0; xfer = 0; zero_bad = 0; bad_rfd = 0; bad_ready = 0;
    bad_gap = 0; first_nd = -1; done_at = -1; done_cnt = 0; mv_cnt = 0;
    abort_k = -1; sclr_k = -1; nd_on_abort = 0; busy_after_abort = 1;
    timeout = 1; sclr_snap = '1; nd_prev = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    for (int i = 0; i < 3; i++) yp[i] = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (m_valid && mv_cnt < 512) begin
        mlog[mv_cnt] = m_data;
        mv_cnt++;
      end
      if (abort_k >= 0 && k == abort_k + 1) busy_after_abort = int'(busy);
      fir_rfd = (rfd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (sv_mode != 0) ? (k % 3 != 2) : 1'b1;
      s_data  = (dmode == 0) ? 16'(xfer + 1)
                             : ((xfer == 1) ? 16'd1 : 16'd0);
      start   = (k == 0) || (k == restart_at) || (k == done_at);
      abort   = (abort_at >= 0 && abort_k < 0 && xfer == abort_at);
      fir_data_valid = nd_prev;
      fir_dout = yp[2];
      yp[2] = yp[1]; yp[1] = yp[0]; yp[0] = '0;
      #1;
      if (s_ready) begin
        if (!fir_rfd || nd_total < 107 || nd_total >= 235) bad_ready++;
        if (fir_nd && !s_valid) bad_gap++;
      end
      if (fir_nd) begin
        if (!fir_rfd) bad_rfd++;
        if (first_nd < 0) first_nd = k;
        if (s_ready) begin
          if (xfer < 128) slog[xfer] = fir_din;
          xfer++;
        end else if (fir_din != 16'd0) begin
          zero_bad++;
        end
        hist[3] = hist[2]; hist[2] = hist[1];
        hist[1] = hist[0]; hist[0] = fir_din;
        y = '0;
        for (int i = 0; i < 4; i++) y = y + 32'(hist[i]) * taps[i];
        yp[0] = y;
        nd_total++;
      end
      if (abort) begin
        abort_k = k;
        nd_on_abort = int'(fir_nd);
      end
      nd_prev = fir_nd;
      if (sclr_at_nd >= 0 && sclr_k < 0 && nd_total >= sclr_at_nd) begin
        sclr = 1'b1;
        sclr_k = k;
        #1;
        sclr_snap = {busy, done, fir_nd, s_ready, m_valid,
                     |m_data, |out_cnt};
        timeout = 0;
        break;
      end
      if (done_at >= 0 && k >= done_at + 3) begin
        timeout = 0;
        break;
      end
      if (abort_k >= 0 && k >= abort_k + 30) begin
        timeout = 0;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    fir_data_valid = 1'b0; fir_dout = '0;
    fir_rfd = 1'b1; s_valid = 1'b1;
    if (timeout != 0) begin
      checks++; fails++;
      $display("FAIL frame_timeout: no done/abort exit within budget");
    end
  endtask

  task automatic test_reset;
    sclr = 1'b1; start = 1'b0; abort = 1'b0;
    fir_rfd = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    fir_data_valid = 1'b1; fir_dout = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL rst_busy_done got %b want 00", {busy, done});
    end
    checks++;
    if ({fir_nd, s_ready} !== 2'b00) begin
      fails++; $display("FAIL rst_nd_ready got %b want 00", {fir_nd, s_ready});
    end
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'd0) begin
      fails++; $display("FAIL rst_m got %b/%h want 0/0", m_valid, m_data);
    end
    checks++;
    if (out_cnt !== 16'd0) begin
      fails++; $display("FAIL rst_out_cnt got %0d want 0", out_cnt);
    end
    sclr = 1'b0; fir_data_valid = 1'b0; fir_dout = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fir_nd !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_start got busy=%b nd=%b mv=%b want 0",
               busy, fir_nd, m_valid);
    end
  endtask

  task automatic test_full_frame;
    int seq_bad;
    run_frame(0, 0, 0, -1, -1, 150);
    seq_bad = 0;
    for (int i = 0; i < 128; i++) if (slog[i] !== 16'(i + 1)) seq_bad++;
    checks++;
    if (nd_total !== 278) begin
      fails++; $display("FAIL full_nd got %0d want 278", nd_total);
    end
    checks++;
    if (first_nd !== 1) begin
      fails++; $display("FAIL full_first_nd got %0d want 1", first_nd);
    end
    checks++;
    if (done_at - first_nd !== 298) begin
      fails++;
      $display("FAIL full_done_lat got %0d want 298", done_at - first_nd);
    end
    checks++;
    if (done_cnt !== 1) begin
      fails++; $display("FAIL full_done_pulses got %0d want 1", done_cnt);
    end
    checks++;
    if (zero_bad !== 0 || bad_ready !== 0) begin
      fails++;
      $display("FAIL full_zero_ready got %0d/%0d want 0/0",
               zero_bad, bad_ready);
    end
    checks++;
    if (xfer !== 128 || seq_bad !== 0) begin
      fails++;
      $display("FAIL full_data got xfer=%0d bad=%0d want 128/0",
               xfer, seq_bad);
    end
    checks++;
    if (mv_cnt !== 278 || out_cnt !== 16'd278) begin
      fails++;
      $display("FAIL full_out_cnt got %0d/%0d want 278/278", mv_cnt, out_cnt);
    end
  endtask

  task automatic test_back_to_back;
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL start_on_done got busy=%b want 0", busy);
    end
  endtask

  task automatic test_impulse;
    run_frame(0, 0, 1, -1, -1, -1);
    checks++;
    if (mlog[107] !== 32'd0 || mlog[112] !== 32'd0) begin
      fails++;
      $display("FAIL imp_edges got %h/%h want 0/0", mlog[107], mlog[112]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mlog[108 + i] !== taps[i]) begin
        fails++;
        $display("FAIL imp_tap%0d got %h want %h", i, mlog[108 + i], taps[i]);
      end
    end
    checks++;
    if (mv_cnt !== 278) begin
      fails++; $display("FAIL imp_mv_cnt got %0d want 278", mv_cnt);
    end
  endtask

  task automatic test_rfd_random;
    int seq_bad;
    run_frame(1, 0, 0, -1, -1, -1);
    seq_bad = 0;
    for (int i = 0; i < 128; i++) if (slog[i] !== 16'(i + 1)) seq_bad++;
    checks++;
    if (nd_total !== 278 || done_cnt !== 1) begin
      fails++;
      $display("FAIL rfd_nd got %0d/%0d want 278/1", nd_total, done_cnt);
    end
    checks++;
    if (bad_rfd !== 0 || bad_ready !== 0) begin
      fails++;
      $display("FAIL rfd_viol got %0d/%0d want 0/0", bad_rfd, bad_ready);
    end
    checks++;
    if (seq_bad !== 0) begin
      fails++; $display("FAIL rfd_seq got %0d want 0", seq_bad);
    end
  endtask

  task automatic test_gap;
    int seq_bad;
    run_frame(0, 1, 0, -1, -1, -1);
    seq_bad = 0;
    for (int i = 0; i < 128; i++) if (slog[i] !== 16'(i + 1)) seq_bad++;
    checks++;
    if (bad_gap !== 0) begin
      fails++; $display("FAIL gap_nd got %0d want 0", bad_gap);
    end
    checks++;
    if (xfer !== 128 || seq_bad !== 0 || nd_total !== 278) begin
      fails++;
      $display("FAIL gap_data got xfer=%0d bad=%0d nd=%0d want 128/0/278",
               xfer, seq_bad, nd_total);
    end
  endtask

  task automatic test_abort;
    run_frame(0, 0, 0, 60, -1, -1);
    checks++;
    if (abort_k < 0 || nd_on_abort !== 0) begin
      fails++;
      $display("FAIL abort_nd got k=%0d nd=%0d want nd=0", abort_k, nd_on_abort);
    end
    checks++;
    if (busy_after_abort !== 0 || done_cnt !== 0) begin
      fails++;
      $display("FAIL abort_idle got busy=%0d done=%0d want 0/0",
               busy_after_abort, done_cnt);
    end
    checks++;
    if (nd_total !== 167) begin
      fails++; $display("FAIL abort_nd_total got %0d want 167", nd_total);
    end
    run_frame(0, 0, 0, -1, -1, -1);
    checks++;
    if (nd_total !== 278 || done_cnt !== 1) begin
      fails++;
      $display("FAIL abort_restart got %0d/%0d want 278/1",
               nd_total, done_cnt);
    end
  endtask

  task automatic test_sclr_flush;
    run_frame(0, 0, 0, -1, 240, -1);
    checks++;
    if (sclr_k < 0 || sclr_snap !== 7'd0) begin
      fails++;
      $display("FAIL sclr_async got k=%0d snap=%b want 0000000",
               sclr_k, sclr_snap);
    end
    sclr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL sclr_release got busy=%b done=%b want 0/0", busy, done);
    end
    run_frame(0, 0, 0, -1, -1, -1);
    checks++;
    if (nd_total !== 278 || first_nd !== 1 || done_cnt !== 1) begin
      fails++;
      $display("FAIL sclr_restart got nd=%0d first=%0d done=%0d want 278/1/1",
               nd_total, first_nd, done_cnt);
    end
  endtask

  initial begin
    taps[0] = 32'h0000_0011;
    taps[1] = 32'h0000_0022;
    taps[2] = 32'h0000_0033;
    taps[3] = 32'h0000_0044;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_impulse();
    test_rfd_random();
    test_gap();
    test_abort();
    test_sclr_flush();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
